// File: rtl/mem48_byte_loader.sv
// mem48_byte_loader: packs a valid/ready byte stream into 48-bit words and writes them to consecutive memory words
//   clk, rst (async, active-high)
//   start, base_addr, word_count : load request, sampled in IDLE
//   in_valid, in_data, in_ready  : byte stream handshake
//   mem_addr, mem_we, mem_wdata  : single-port memory write interface
//   mem_rdata                    : memory read data, used only for readback
//   busy, done, err              : status (err only with MEM48_LOADER_READBACK_EN)
// Optional readback verification is enabled by defining MEM48_LOADER_READBACK_EN.
module mem48_byte_loader #(
  parameter int WORDS = 16384,
  parameter bit MSB_FIRST = 1'b1,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   word_count,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [47:0]   mem_wdata,
  input  logic [47:0]   mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, VERIFY, DONE} state_t;
`ifdef MEM48_LOADER_READBACK_EN
  localparam state_t ADV_STATE = VERIFY;
`else
  localparam state_t ADV_STATE = WRITE;
`endif
  state_t state, state_nx, adv_nx;
  logic [AW-1:0] addr;
  logic [AW:0] remaining;
  logic [2:0] byte_idx;
  logic [47:0] sr, sr_nx;
  logic take, last_byte, adv;
  assign take = (state == COLLECT) && in_valid;
  assign last_byte = take && (byte_idx == 3'd5);
  assign adv = (state == ADV_STATE);
  assign adv_nx = (remaining == (AW+1)'(1)) ? DONE : COLLECT;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? ((word_count != '0) ? COLLECT : DONE) : IDLE;
      COLLECT: state_nx = last_byte ? WRITE : COLLECT;
`ifdef MEM48_LOADER_READBACK_EN
      WRITE: state_nx = VERIFY;
      VERIFY: state_nx = adv_nx;
`else
      WRITE: state_nx = adv_nx;
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = (state == COLLECT);
    mem_we = (state == WRITE);
    busy = (state != IDLE);
    done = (state == DONE);
  end
  // MSB-first shifts bytes in from the bottom so the first byte ends in [47:40];
  // LSB-first drops each byte straight into its lane.
  always_comb begin
    sr_nx = sr;
    if (MSB_FIRST) sr_nx = {sr[39:0], in_data};
    else sr_nx[{byte_idx, 3'b000} +: 8] = in_data;
  end
  // mem_addr/mem_wdata are loaded only on the final byte, so they hold the
  // last written word while the next one is being collected.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      remaining <= '0;
      byte_idx <= '0;
      sr <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      if (state == IDLE && start) begin
        addr <= base_addr;
        remaining <= word_count;
        byte_idx <= '0;
      end
      if (take) begin
        sr <= sr_nx;
        byte_idx <= last_byte ? 3'd0 : byte_idx + 3'd1;
      end
      if (last_byte) begin
        mem_addr <= addr;
        mem_wdata <= sr_nx;
      end
      if (adv) begin
        remaining <= remaining - (AW+1)'(1);
        addr <= (addr == AW'(WORDS - 1)) ? '0 : addr + AW'(1);
        byte_idx <= '0;
      end
    end
`ifdef MEM48_LOADER_READBACK_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else if (state == IDLE && start) err <= 1'b0;
    else if (state == VERIFY && mem_rdata != mem_wdata) err <= 1'b1;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign err = 1'b0;
`endif
endmodule
